// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional macro RISCV_MC_BNE_EN enables bne (funct3=001) in the BEQ state; otherwise it is flagged illegal.
module riscv_mc_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter int         MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       IllegalInstr,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [2:0]      funct_alu;
  logic            funct_illegal;
  logic            mem_wait;
  logic            timeout;

  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= state_t'(RESET_STATE);
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // SUB only for R-type (op[5]=1) with funct7b5; funct3=011 has no ALU op here.
  always_comb begin
    funct_alu     = 3'b000;
    funct_illegal = 1'b0;
    case (funct3)
      3'b000:  funct_alu = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b111:  funct_alu = 3'b010;
      3'b110:  funct_alu = 3'b011;
      3'b100:  funct_alu = 3'b100;
      3'b010:  funct_alu = 3'b101;
      3'b001:  funct_alu = 3'b110;
      3'b101:  funct_alu = 3'b111;
      default: funct_illegal = 1'b1;
    endcase
  end

  // MemReady handshake: the FSM holds its memory request every cycle until
  // MemReady=1, which marks the access complete in that same cycle.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE)) && !MemReady;
  assign timeout  = (MEM_TIMEOUT > 0) && mem_wait && (wait_cnt_q == CW'(MEM_TIMEOUT));

  always_comb begin
    state_d      = state_q;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ImmSrc       = 2'b00;
    RegWrite     = 1'b0;
    ALUControl   = 3'b000;
    IllegalInstr = 1'b0;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b10;
        if (MemReady) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ResultSrc = 2'b10;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? 2'b01 : 2'b00;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        ALUControl   = funct_alu;
        IllegalInstr = funct_illegal;
        state_d      = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        ImmSrc       = 2'b00;
        ALUControl   = funct_alu;
        IllegalInstr = funct_illegal;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b001;
        state_d    = S_FETCH;
        case (funct3)
          3'b000: PCWrite = Zero;
`ifdef RISCV_MC_BNE_EN
          3'b001: PCWrite = ~Zero;
`endif
          default: IllegalInstr = 1'b1;
        endcase
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    if (timeout) begin
      IllegalInstr = 1'b1;
      state_d      = S_FETCH;
    end

    // FETCH->FETCH on timeout is not a state change, so clear explicitly.
    if ((MEM_TIMEOUT == 0) || timeout || (state_d != state_q)) begin
      wait_cnt_d = '0;
    end else if (mem_wait) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end

    // Reset mid-instruction must not leak a partial write.
    if (reset) begin
      PCWrite      = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b10;
      ImmSrc       = 2'b00;
      ALUControl   = 3'b000;
    end
  end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller: directed vector table, reset/timeout sequences and
// random instructions checked cycle by cycle against an instruction-level trace model.
module tb_riscv_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;

  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] dbg_state;

  logic       t_PCWrite, t_AdrSrc, t_MemRead, t_MemWrite, t_IRWrite, t_RegWrite, t_IllegalInstr;
  logic [1:0] t_ResultSrc, t_ALUSrcA, t_ALUSrcB, t_ImmSrc;
  logic [2:0] t_ALUControl;
  logic [3:0] t_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9, S_JAL = 10;

`ifdef RISCV_MC_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  always #5 clk = ~clk;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .IllegalInstr(IllegalInstr), .dbg_state_o(dbg_state)
  );

  riscv_mc_controller #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc),
    .MemRead(t_MemRead), .MemWrite(t_MemWrite), .IRWrite(t_IRWrite), .ResultSrc(t_ResultSrc),
    .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB), .ImmSrc(t_ImmSrc), .RegWrite(t_RegWrite),
    .ALUControl(t_ALUControl), .IllegalInstr(t_IllegalInstr), .dbg_state_o(t_dbg_state)
  );

  // Expected word: {state[3:0], value[17:0], care[17:0]}.
  // Output bits: 17 PCWrite,16 AdrSrc,15 MemRead,14 MemWrite,13 IRWrite,12:11 ResultSrc,
  // 10:9 ALUSrcA,8:7 ALUSrcB,6:5 ImmSrc,4 RegWrite,3:1 ALUControl,0 IllegalInstr.
  logic [39:0] exp_q[$];
  logic [1:0]  stim_q[$];
  logic [17:0] obs_out[16];
  logic [3:0]  obs_st[16];

  function automatic logic [17:0] pack_out();
    return {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, RegWrite, ALUControl, IllegalInstr};
  endfunction

  // Negative mux arguments mean "not specified for this state".
  function automatic logic [39:0] mk(int st, int pcw, int adr, int mr, int mw, int irw, int rs,
                                     int asa, int asb, int imm, int rw, int alu, int ill);
    logic [17:0] v, c;
    v = '0; c = '0;
    v[17] = pcw[0]; c[17] = 1'b1;
    if (adr >= 0) begin v[16] = adr[0]; c[16] = 1'b1; end
    v[15] = mr[0];  c[15] = 1'b1;
    v[14] = mw[0];  c[14] = 1'b1;
    v[13] = irw[0]; c[13] = 1'b1;
    if (rs >= 0)  begin v[12:11] = rs[1:0];  c[12:11] = 2'b11; end
    if (asa >= 0) begin v[10:9]  = asa[1:0]; c[10:9]  = 2'b11; end
    if (asb >= 0) begin v[8:7]   = asb[1:0]; c[8:7]   = 2'b11; end
    if (imm >= 0) begin v[6:5]   = imm[1:0]; c[6:5]   = 2'b11; end
    v[4] = rw[0]; c[4] = 1'b1;
    v[3:1] = alu[2:0]; c[3:1] = 3'b111;
    v[0] = ill[0]; c[0] = 1'b1;
    return {st[3:0], v, c};
  endfunction

  function automatic int ref_alu(logic [2:0] f3, logic f7, logic op5);
    case (f3)
      3'd0: return (op5 && f7) ? 1 : 0;
      3'd7: return 2;
      3'd6: return 3;
      3'd4: return 4;
      3'd2: return 5;
      3'd1: return 6;
      3'd5: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic push(input logic [39:0] e, input int mr, input int z);
    logic mrb, zb;
    mrb = (mr < 0) ? 1'($urandom_range(0, 1)) : mr[0];
    zb  = (z < 0)  ? 1'($urandom_range(0, 1)) : z[0];
    exp_q.push_back(e);
    stim_q.push_back({mrb, zb});
  endtask

  // Instruction-level model: emits the expected per-cycle trace of one instruction.
  task automatic model_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
    int alu, ill, pcw, bill;
    alu = ref_alu(f3, f7, o[5]);
    ill = (f3 == 3'd3) ? 1 : 0;
    repeat (fw) push(mk(S_FETCH, 0, 0, 1, 0, 0, -1, 0, 2, -1, 0, 0, 0), 0, -1);
    push(mk(S_FETCH, 1, 0, 1, 0, 1, 2, 0, 2, -1, 0, 0, 0), 1, -1);
    case (o)
      7'b0000011, 7'b0100011: begin
        push(mk(S_DECODE, 0, -1, 0, 0, 0, -1, 1, 1, 2, 0, 0, 0), -1, -1);
        push(mk(S_MEMADR, 0, -1, 0, 0, 0, -1, 2, 1, o[5] ? 1 : 0, 0, 0, 0), -1, -1);
        if (!o[5]) begin
          repeat (mw) push(mk(S_MEMREAD, 0, 1, 1, 0, 0, 0, -1, -1, -1, 0, 0, 0), 0, -1);
          push(mk(S_MEMREAD, 0, 1, 1, 0, 0, 0, -1, -1, -1, 0, 0, 0), 1, -1);
          push(mk(S_MEMWB, 0, -1, 0, 0, 0, 1, -1, -1, -1, 1, 0, 0), -1, -1);
        end else begin
          repeat (mw) push(mk(S_MEMWRITE, 0, 1, 0, 1, 0, 0, -1, -1, -1, 0, 0, 0), 0, -1);
          push(mk(S_MEMWRITE, 0, 1, 0, 1, 0, 0, -1, -1, -1, 0, 0, 0), 1, -1);
        end
      end
      7'b0110011, 7'b0010011: begin
        push(mk(S_DECODE, 0, -1, 0, 0, 0, -1, 1, 1, 2, 0, 0, 0), -1, -1);
        if (o[5]) push(mk(S_EXECR, 0, -1, 0, 0, 0, -1, 2, 0, -1, 0, alu, ill), -1, -1);
        else      push(mk(S_EXECI, 0, -1, 0, 0, 0, -1, 2, 1, 0, 0, alu, ill), -1, -1);
        push(mk(S_ALUWB, 0, -1, 0, 0, 0, 0, -1, -1, -1, 1, 0, 0), -1, -1);
      end
      7'b1100011: begin
        pcw  = (f3 == 3'd0) ? int'(z) : ((f3 == 3'd1 && BNE) ? int'(!z) : 0);
        bill = (f3 == 3'd0 || (f3 == 3'd1 && BNE)) ? 0 : 1;
        push(mk(S_DECODE, 0, -1, 0, 0, 0, -1, 1, 1, 2, 0, 0, 0), -1, -1);
        push(mk(S_BEQ, pcw, -1, 0, 0, 0, 0, 2, 0, -1, 0, 1, bill), -1, int'(z));
      end
      7'b1101111: begin
        push(mk(S_DECODE, 0, -1, 0, 0, 0, -1, 1, 1, 2, 0, 0, 0), -1, -1);
        push(mk(S_JAL, 1, -1, 0, 0, 0, 0, 1, 2, -1, 0, 0, 0), -1, -1);
        push(mk(S_ALUWB, 0, -1, 0, 0, 0, 0, -1, -1, -1, 1, 0, 0), -1, -1);
      end
      default: push(mk(S_DECODE, 0, -1, 0, 0, 0, -1, 1, 1, 2, 0, 0, 1), -1, -1);
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int fw, input int mw);
    logic [39:0] e;
    logic [1:0]  s;
    logic [17:0] got;
    int idx;
    op = o; funct3 = f3; funct7b5 = f7;
    model_instr(o, f3, f7, z, fw, mw);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      MemReady = s[1];
      Zero     = s[0];
      @(negedge clk);
      got = pack_out();
      if (idx < 16) begin
        obs_out[idx] = got;
        obs_st[idx]  = dbg_state;
      end
      n_checks++;
      if (dbg_state !== e[39:36] || ((got ^ e[35:18]) & e[17:0]) != 18'd0) begin
        n_errors++;
        $display("FAIL %s cyc%0d: state=%0d out=%b, required state=%0d out=%b care=%b",
                 tag, idx, dbg_state, got, e[39:36], e[35:18], e[17:0]);
      end
      step();
      idx++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         fw;
    int         mw;
    int         key;
    logic [3:0] k_st;
    logic       k_pcw;
    logic [2:0] k_alu;
    logic       k_ill;
  } vec_t;

  vec_t vt[17];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b000, 1'b0}; // add
    vt[1]  = '{7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b001, 1'b0}; // sub
    vt[2]  = '{7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0, 2, 4'd7,  1'b0, 3'b000, 1'b0}; // addi f7=1
    vt[3]  = '{7'b0110011, 3'd5, 1'b0, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b111, 1'b0}; // srl
    vt[4]  = '{7'b0110011, 3'd6, 1'b0, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b011, 1'b0}; // or
    vt[5]  = '{7'b0010011, 3'd7, 1'b0, 1'b0, 0, 0, 2, 4'd7,  1'b0, 3'b010, 1'b0}; // andi
    vt[6]  = '{7'b0110011, 3'd4, 1'b0, 1'b1, 2, 0, 4, 4'd6,  1'b0, 3'b100, 1'b0}; // xor, slow fetch
    vt[7]  = '{7'b0010011, 3'd2, 1'b0, 1'b0, 0, 0, 2, 4'd7,  1'b0, 3'b101, 1'b0}; // slti
    vt[8]  = '{7'b0110011, 3'd1, 1'b0, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b110, 1'b0}; // sll
    vt[9]  = '{7'b0110011, 3'd3, 1'b0, 1'b0, 0, 0, 2, 4'd6,  1'b0, 3'b000, 1'b1}; // funct3=011
    vt[10] = '{7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 2, 4'd9,  1'b1, 3'b001, 1'b0}; // beq taken
    vt[11] = '{7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0, 2, 4'd9,  1'b0, 3'b001, 1'b0}; // beq not taken
`ifdef RISCV_MC_BNE_EN
    vt[12] = '{7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, 2, 4'd9,  1'b1, 3'b001, 1'b0}; // bne taken
`else
    vt[12] = '{7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0, 2, 4'd9,  1'b0, 3'b001, 1'b1}; // bne unsupported
`endif
    vt[13] = '{7'b1100011, 3'd4, 1'b0, 1'b1, 0, 0, 2, 4'd9,  1'b0, 3'b001, 1'b1}; // blt unsupported
    vt[14] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0, 2, 4'd10, 1'b1, 3'b000, 1'b0}; // jal
    vt[15] = '{7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 1, 4'd1,  1'b0, 3'b000, 1'b1}; // illegal op
    vt[16] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, 2, 4'd2,  1'b0, 3'b000, 1'b0}; // lw, 3 wait cycles

    reset = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; Zero = 1'b0; MemReady = 1'b1;

    // Two reset cycles with MemReady high: enables must stay low, muxes at FETCH values.
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      chk("rst_enables", {26'd0, PCWrite, MemRead, MemWrite, IRWrite, RegWrite, IllegalInstr}, 32'd0);
      chk("rst_muxes", {24'd0, AdrSrc, ALUSrcA, ALUSrcB, ALUControl}, 32'h10);
    end
    step();
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_instr($sformatf("vec%0d", i), vt[i].op, vt[i].f3, vt[i].f7, vt[i].zero, vt[i].fw, vt[i].mw);
      n_checks++;
      if (obs_st[vt[i].key] !== vt[i].k_st || obs_out[vt[i].key][17] !== vt[i].k_pcw ||
          obs_out[vt[i].key][3:1] !== vt[i].k_alu || obs_out[vt[i].key][0] !== vt[i].k_ill) begin
        n_errors++;
        $display("FAIL vec%0d key: state=%0d pcw=%b alu=%b ill=%b, required state=%0d pcw=%b alu=%b ill=%b",
                 i, obs_st[vt[i].key], obs_out[vt[i].key][17], obs_out[vt[i].key][3:1],
                 obs_out[vt[i].key][0], vt[i].k_st, vt[i].k_pcw, vt[i].k_alu, vt[i].k_ill);
      end
    end

    // Reset while a store waits in MEMWRITE.
    op = 7'b0100011; funct3 = 3'd2; MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("sw_memwrite_state", dbg_state, S_MEMWRITE);
    chk("sw_memwrite_en", MemWrite, 1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_sw_memwrite", MemWrite, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sw_fetch", dbg_state, S_FETCH);
    step();

    // Reset in ALUWB must suppress the register write.
    op = 7'b0110011; funct3 = 3'd0; MemReady = 1'b1;
    step();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_aluwb_state", dbg_state, S_ALUWB);
    chk("rst_aluwb_regwrite", RegWrite, 0);
    step();
    reset = 1'b0;
    MemReady = 1'b0;
    @(negedge clk);
    chk("rst_aluwb_fetch", dbg_state, S_FETCH);
    step();

    // Timeout instance: lw with MemReady stuck low in MEMREAD.
    reset = 1'b1;
    step();
    reset = 1'b0;
    op = 7'b0000011; funct3 = 3'd2; MemReady = 1'b1;
    step();
    MemReady = 1'b0;
    step();
    step();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_state", k), t_dbg_state, S_MEMREAD);
      chk($sformatf("to_wait%0d_ill", k), {t_IllegalInstr, t_MemRead, t_RegWrite}, 3'b010);
      step();
    end
    @(negedge clk);
    chk("to_pulse_state", t_dbg_state, S_MEMREAD);
    chk("to_pulse_ill", t_IllegalInstr, 1);
    step();
    @(negedge clk);
    chk("to_after_state", t_dbg_state, S_FETCH);
    chk("to_after_ill", t_IllegalInstr, 0);
    chk("no_to_default", dbg_state, S_MEMREAD);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Random instruction stream.
    for (int i = 0; i < 60; i++) begin
      logic [6:0] ro;
      case ($urandom_range(0, 6))
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: ro = 7'b0110011;
        3: ro = 7'b0010011;
        4: ro = 7'b1100011;
        5: ro = 7'b1101111;
        default: ro = 7'($urandom_range(0, 127));
      endcase
      run_instr($sformatf("rnd%0d", i), ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
